fpm_rr_scheduler: RTL and testbench
===================================

Name: fpm_rr_scheduler

Overview:
- Shares one single-precision floating-point multiplier datapath between N requesters.
- Round-robin arbitration, one operation in flight at a time.
- Latches the granted operand pair and drives it to the multiplier for a fixed LATENCY cycles, then captures the product and returns it with the requester id over a valid/ready response port.
- Sits between client blocks and the multiplier core; the multiplier core is instantiated outside this block.

Parameters:
- N, 4, number of requesters (≥2).
- LATENCY, 2, cycles the multiplier inputs are held stable before the product is sampled (≥1).
- IDW, $clog2(N), requester-id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_a  in  N*32  packed operand A, requester i at [32i+31:32i].
- req_b  in  N*32  packed operand B, same packing.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_p  in  32  product from the multiplier, IEEE-754 single.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  32  product.
- rsp_id  out  IDW  index of the requester served.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high on clk/rst.
- Reset values:
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; mul_a=mul_b=0; busy=0.
  - Grant pointer last=N-1, so requester 0 has top priority first.
  - req_ready=0 while rst is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready[g]=1 combinationally for g = first i with req_valid[i], searching last+1 … last+N modulo N.
  - On the handshake, register a, b and id=g into mul_a, mul_b, rsp_id.
  - Load cnt=LATENCY-1, set last=g, go to WAIT.
  - No valid requests: stay in IDLE, all req_ready=0.
- WAIT:
  - mul_a and mul_b hold stable.
  - cnt decrements each cycle.
  - When cnt=0, capture mul_p into rsp_data, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id hold until rsp_ready=1.
  - On the handshake, clear rsp_valid and go to IDLE.
  - Requests are not accepted in RESP.
- Latency: request accepted in cycle t → rsp_valid first high in cycle t+LATENCY+1. Minimum issue interval is LATENCY+2 cycles.
- Requesters must hold req_valid, req_a and req_b until req_ready. The scheduler never drops an accepted request.
- Pointer update: last changes only on a request handshake. A requester dropping req_valid before grant loses its turn without penalty.
- rsp_ready low indefinitely: block stays in RESP, busy=1, all req_ready=0.
- rst asserted mid-operation (WAIT or RESP): the in-flight operation is discarded and all registers return to reset values next edge, with no response emitted.
- No arithmetic is done here; the product value is exactly mul_p as sampled.

Optional Feature:
- Macro: FPM_SPECIAL_BYPASS_EN.
- Defined:
  - In IDLE, on handshake, classify the operands.
  - If either operand has exponent 0xFF and mantissa 0 (infinity), result = 0x7F800000.
  - Else if either operand has exponent 0 and mantissa 0 (zero), result = 0x00000000. Infinity is checked before zero, so inf×0 → 0x7F800000.
  - On a special case, skip WAIT: load rsp_data with the result, go directly to RESP, rsp_valid at t+1. mul_a and mul_b stay unchanged.
- Undefined: all operands take the WAIT path.

Decomposition:
- Package fpm_pkg:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - FP_POS_INF=32'h7F800000, FP_POS_ZERO=32'h0.
  - State enum {IDLE, WAIT, RESP}.
  - Functions is_inf() and is_zero().
- Sub-module rr_arbiter (N): inputs req and last pointer, outputs one-hot grant and encoded index. Purely combinational, and reused by other shared units.

Test Plan:
- Single op, requester 2, a=0x40000000 (2.0), b=0x40800000 (4.0), model multiplier returns 0x41000000, LATENCY=2, rsp_ready=1 → req_ready[2] at t, rsp_valid at t+3, rsp_data=0x41000000, rsp_id=2.
- All four req_valid held after reset → grants in order 0,1,2,3,0; each grant spaced LATENCY+2 cycles; rsp_id sequence matches.
- rsp_ready held low 10 cycles during RESP → rsp_valid/rsp_data/rsp_id stable, req_ready=0, busy=1; release → IDLE next cycle, next grant the cycle after.
- rst pulsed in the WAIT cycle → next cycle rsp_valid=0, busy=0; no response for that request; first grant after reset goes to requester 0.
- FPM_SPECIAL_BYPASS_EN defined, a=0x7F800000, b=0x00000000 → rsp_valid at t+1, rsp_data=0x7F800000, mul_a unchanged.
- Same macro, a=0x00000000, b=0x42FA4000 → rsp_data=0x00000000 at t+1.
- Macro undefined, same operands → WAIT path, rsp_valid at t+LATENCY+1.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared definitions for the floating-point multiplier scheduler:
// IEEE-754 single-precision field widths, special-value constants,
// the scheduler state encoding and operand classification helpers.
package fpm_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True for +/- infinity: all-ones exponent with an empty mantissa.
  function automatic logic is_inf(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] == '0);
  endfunction

  // True for +/- zero: zero exponent with an empty mantissa.
  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '0) && (x[MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fpm_rr_scheduler_if.sv
// Bundle of request, multiplier and response signals of the scheduler.
// The slave modport is the scheduler's view; the master modport is the
// view of whatever surrounds it (clients plus the multiplier core).
interface fpm_rr_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  import fpm_pkg::*;

  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*FP_W-1:0] req_a;
  logic [N*FP_W-1:0] req_b;
  logic [FP_W-1:0]   mul_a;
  logic [FP_W-1:0]   mul_b;
  logic [FP_W-1:0]   mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [FP_W-1:0]   rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/fpm_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter. Searches last+1 ... last+N (mod N)
// and grants the first active request. Holds no state, so any shared unit
// can pair it with its own pointer register.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] cand;

  // Walk the rotated priority order and stop at the first request seen.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpm_rr_scheduler.sv
// Round-robin scheduler sharing one single-precision multiplier between N
// requesters. One operation in flight: the granted operands are held on
// mul_a/mul_b for LATENCY cycles, then mul_p is captured and returned with
// the requester id on a valid/ready response port.
// Optional feature FPM_SPECIAL_BYPASS_EN: infinity/zero operands are
// answered directly from IDLE without using the multiplier.
module fpm_rr_scheduler
  import fpm_pkg::*;
#(
  parameter int N       = 4,
  parameter int LATENCY = 2,
  parameter int IDW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  fpm_rr_scheduler_if.slave  bus
);

  localparam int             CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [FP_W-1:0] mul_a_q, mul_a_d;
  logic [FP_W-1:0] mul_b_q, mul_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [N-1:0]    gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [FP_W-1:0] a_sel, b_sel;
  logic            bypass_hit;
  logic [FP_W-1:0] bypass_res;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Operand mux: the grant is one-hot, so OR-ing the selected lanes is exact.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        a_sel = a_sel | bus.req_a[i*FP_W +: FP_W];
        b_sel = b_sel | bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

`ifdef FPM_SPECIAL_BYPASS_EN
  // Classify the granted operands; infinity takes precedence over zero.
  always_comb begin
    bypass_hit = 1'b0;
    bypass_res = FP_POS_ZERO;
    if (is_inf(a_sel) || is_inf(b_sel)) begin
      bypass_hit = 1'b1;
      bypass_res = FP_POS_INF;
    end else if (is_zero(a_sel) || is_zero(b_sel)) begin
      bypass_hit = 1'b1;
      bypass_res = FP_POS_ZERO;
    end
  end
`else
  assign bypass_hit = 1'b0;
  assign bypass_res = FP_POS_ZERO;
`endif

  // Next-state logic: arbitration in IDLE, latency count in WAIT,
  // response hold in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          last_d   = gnt_idx;
          rsp_id_d = gnt_idx;
          if (bypass_hit) begin
            // Multiplier inputs are left untouched on the bypass path.
            rsp_data_d  = bypass_res;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            mul_a_d = a_sel;
            mul_b_d = b_sel;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = bus.mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; an in-flight operation is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: all registers here drive visible outputs or steer control, so
      // every one of them is reset, including the operand and data registers.
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDW'(N - 1);
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= FP_POS_ZERO;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// Self-checking bench for fpm_rr_scheduler. A transaction-timeline model
// (accept cycle + response latency, round-robin pick from the rule) predicts
// every output each cycle; directed steps cover the key scenarios and a
// randomized phase follows.
module tb_fpm_rr_scheduler;
  import fpm_pkg::*;

  localparam int N       = 4;
  localparam int LATENCY = 2;
  localparam int IDW     = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpm_rr_scheduler_if #(.N(N), .IDW(IDW)) bus ();

  fpm_rr_scheduler #(.N(N), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in multiplier: exact for 2.0*4.0, otherwise a deterministic hash.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4080_0000) return 32'h4100_0000;
    return (a * 32'd2654435761) ^ {b[15:0], b[31:16]};
  endfunction

  assign bus.mul_p = model_mul(bus.mul_a, bus.mul_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state (timeline view of the single in-flight operation).
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          cyc, acc_cyc, resp_lat, exp_id, m_last, last_grant;
  bit          outst;
  logic [31:0] exp_data, m_mul_a, m_mul_b;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic void special(input logic [31:0] a, input logic [31:0] b,
                                  output bit hit, output logic [31:0] res);
    int ea, eb, ma, mb;
    ea = int'((a >> 23) & 32'hFF);  ma = int'(a & 32'h7F_FFFF);
    eb = int'((b >> 23) & 32'hFF);  mb = int'(b & 32'h7F_FFFF);
    hit = 1'b0;
    res = 32'h0;
`ifdef FPM_SPECIAL_BYPASS_EN
    if ((ea == 255 && ma == 0) || (eb == 255 && mb == 0)) begin
      hit = 1'b1; res = 32'h7F80_0000;
    end else if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0)) begin
      hit = 1'b1; res = 32'h0;
    end
`endif
  endfunction

  function automatic logic [31:0] normal_op();
    return ($urandom & 32'hBFFF_FFFF) | 32'h0080_0000;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h7F80_0000;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the coming rising edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic rr);
    int          g;
    logic [N-1:0] exp_rdy;
    bit          exp_rv, hit;
    logic [31:0] res;
    logic [N*32-1:0] pa, pb;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      pa[32*i +: 32] = op_a[i];
      pb[32*i +: 32] = op_b[i];
    end
    rst           = r;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req_a     = pa;
    bus.req_b     = pb;
    #1;
    g       = rr_pick(v, m_last);
    exp_rdy = '0;
    if (!outst && !r && g >= 0) exp_rdy[g] = 1'b1;
    exp_rv  = outst && (cyc >= acc_cyc + resp_lat);
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("busy", 32'(bus.busy), 32'(outst));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("mul_a", bus.mul_a, m_mul_a);
    check("mul_b", bus.mul_b, m_mul_b);
    if (exp_rv) begin
      check("rsp_data", bus.rsp_data, exp_data);
      check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    end
    last_grant = (exp_rdy != '0) ? g : -1;
    if (r) begin
      outst = 1'b0; m_last = N - 1; m_mul_a = '0; m_mul_b = '0;
    end else if (exp_rv && rr) begin
      outst = 1'b0;
    end else if (!outst && g >= 0) begin
      outst = 1'b1; acc_cyc = cyc; exp_id = g; m_last = g;
      special(op_a[g], op_b[g], hit, res);
      if (hit) begin
        resp_lat = 1; exp_data = res;
      end else begin
        resp_lat = LATENCY + 1;
        exp_data = model_mul(op_a[g], op_b[g]);
        m_mul_a  = op_a[g];
        m_mul_b  = op_b[g];
      end
    end
    cyc++;
  endtask

  int          gid [8];
  int          gcyc [8];
  int          ng;
  logic [N-1:0] vld;

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = normal_op();
      op_b[i] = normal_op();
    end
    bus.req_valid = '0; bus.rsp_ready = 1'b0; bus.req_a = '0; bus.req_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc = 0; acc_cyc = 0; resp_lat = 0; exp_id = 0; m_last = N - 1;
    outst = 1'b0; exp_data = '0; m_mul_a = '0; m_mul_b = '0; last_grant = -1;

    // Reset state.
    step(1'b1, '0, 1'b0);
    check("reset_rsp_data", bus.rsp_data, 32'h0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);

    // Single op from requester 2: 2.0 * 4.0.
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4080_0000;
    step(1'b0, 4'b0100, 1'b1);
    check("t1_grant", 32'(bus.req_ready), 32'h4);
    step(1'b0, 4'b0000, 1'b1);
    check("t1_valid_t1", 32'(bus.rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    check("t1_valid_t2", 32'(bus.rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    check("t1_valid_t3", 32'(bus.rsp_valid), 32'd1);
    check("t1_data", bus.rsp_data, 32'h4100_0000);
    check("t1_id", 32'(bus.rsp_id), 32'd2);
    step(1'b0, 4'b0000, 1'b1);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // All four requesters held valid after reset: grants 0,1,2,3,0.
    step(1'b1, '0, 1'b1);
    ng = 0;
    for (int k = 0; k < 8; k++) begin gid[k] = -1; gcyc[k] = -100; end
    for (int s = 0; s < 20; s++) begin
      step(1'b0, 4'b1111, 1'b1);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] && ng < 8) begin
          gid[ng] = i; gcyc[ng] = s; ng++;
        end
      end
      if (last_grant >= 0) begin
        op_a[last_grant] = normal_op(); op_b[last_grant] = normal_op();
      end
    end
    check("rr_grant_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("rr_grant_order", 32'(gid[k]), 32'(k % N));
      if (k > 0) check("rr_grant_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(LATENCY + 2));
    end

    // Backpressure: rsp_ready low for 10 RESP cycles.
    step(1'b1, '0, 1'b1);
    op_a[1] = 32'h3FC0_0000; op_b[1] = 32'h4040_0000;
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b1101, 1'b0);
    step(1'b0, 4'b1101, 1'b0);
    for (int s = 0; s < 10; s++) begin
      step(1'b0, 4'b1101, 1'b0);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", bus.rsp_data, model_mul(32'h3FC0_0000, 32'h4040_0000));
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    step(1'b0, 4'b1101, 1'b1);
    step(1'b0, 4'b1101, 1'b1);
    check("bp_release_busy", 32'(bus.busy), 32'd0);
    check("bp_next_grant", 32'(bus.req_ready), 32'h4);

    // Reset during WAIT discards requester 2's operation.
    step(1'b1, 4'b1011, 1'b0);
    step(1'b0, 4'b1111, 1'b1);
    check("rst_wait_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_wait_busy", 32'(bus.busy), 32'd0);
    check("rst_wait_grant", 32'(bus.req_ready), 32'h1);
    repeat (4) step(1'b0, 4'b0000, 1'b1);

    // Special operands: inf*0 from requester 1, 0*125.125 from requester 3.
    step(1'b1, '0, 1'b1);
    op_a[1] = 32'h7F80_0000; op_b[1] = 32'h0000_0000;
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
`ifdef FPM_SPECIAL_BYPASS_EN
    check("byp_inf_valid", 32'(bus.rsp_valid), 32'd1);
    check("byp_inf_data", bus.rsp_data, 32'h7F80_0000);
    check("byp_inf_mul_a", bus.mul_a, 32'h0);
    step(1'b0, 4'b0000, 1'b1);
`else
    check("nobyp_inf_t1", 32'(bus.rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    check("nobyp_inf_t3", 32'(bus.rsp_valid), 32'd1);
    check("nobyp_inf_data", bus.rsp_data, model_mul(32'h7F80_0000, 32'h0));
    step(1'b0, 4'b0000, 1'b1);
`endif
    op_a[3] = 32'h0000_0000; op_b[3] = 32'h42FA_4000;
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
`ifdef FPM_SPECIAL_BYPASS_EN
    check("byp_zero_valid", 32'(bus.rsp_valid), 32'd1);
    check("byp_zero_data", bus.rsp_data, 32'h0);
    step(1'b0, 4'b0000, 1'b1);
`else
    check("nobyp_zero_t1", 32'(bus.rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    check("nobyp_zero_t3", 32'(bus.rsp_valid), 32'd1);
    check("nobyp_zero_id", 32'(bus.rsp_id), 32'd3);
    step(1'b0, 4'b0000, 1'b1);
`endif

    // Randomized traffic, backpressure, drops and occasional resets.
    vld = '0;
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 9) < 3) begin
          vld[i] = 1'b1; op_a[i] = rand_op(); op_b[i] = rand_op();
        end else if (vld[i] && $urandom_range(0, 99) < 3) begin
          vld[i] = 1'b0;
        end
      end
      step(($urandom_range(0, 99) == 0), vld, ($urandom_range(0, 9) < 7));
      if (last_grant >= 0) vld[last_grant] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
